// File: rtl/pool_pkg.sv
// pool_pkg: FSM states, reduction mode encodings and log2 helper shared by the pooling stage
package pool_pkg;

    typedef enum logic [2:0] {IDLE, WAIT_BUF, FETCH, DRAIN, WRITE, DONE} state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    function automatic int flog2(input int n);
        int r;
        r = 0;
        while ((1 << (r + 1)) <= n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pool_reduce.sv
// pool_reduce: running max / sum of one window; result already folds in the sample arriving this cycle
module pool_reduce
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  first,
    input  logic                  valid,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int AW = DATA_WIDTH + 2 * $clog2(KERNEL_SIZE);
    localparam int SH = flog2(KERNEL_SIZE * KERNEL_SIZE);

    if ((1 << SH) != KERNEL_SIZE * KERNEL_SIZE) begin : g_bad_kernel
        $error("pool_reduce: average needs KERNEL_SIZE*KERNEL_SIZE to be a power of two");
    end

    logic signed [AW-1:0] acc, ext, nxt;

    // next accumulator value; the mean is a floor shift, exact after truncation to the input width
    always_comb begin
        ext    = {{(AW - DATA_WIDTH){data[DATA_WIDTH-1]}}, data};
        nxt    = first ? ext : (mode == MODE_AVG) ? acc + ext : (ext > acc) ? ext : acc;
        result = DATA_WIDTH'((mode == MODE_AVG) ? nxt >>> SH : nxt);
    end

    // accumulate each returning sample
    always_ff @(posedge clk) begin
        if (reset) acc <= '0;
        else if (valid) acc <= nxt;
    end

endmodule

// File: rtl/pool_engine.sv
// pool_engine: KxK max/average pooling with ping-pong output banks; define POOL_RELU_EN to write negative results as 0
module pool_engine
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int IFM_SIZE    = 28,
    parameter int IFM_DEPTH   = 6,
    parameter int KERNEL_SIZE = 2,
    parameter int STRIDE      = 2,
    parameter int OFM_SIZE    = (IFM_SIZE - KERNEL_SIZE) / STRIDE + 1,
    parameter int ADDR_IN     = $clog2(IFM_DEPTH * IFM_SIZE * IFM_SIZE),
    parameter int ADDR_OUT    = $clog2(IFM_DEPTH * OFM_SIZE * OFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_from_previous,
    input  logic                  mode_avg,
    output logic                  ifm_enable_read,
    output logic [ADDR_IN-1:0]    ifm_address_read,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  end_to_previous,
    input  logic                  end_from_next,
    output logic                  ifm_enable_write_next,
    output logic [ADDR_OUT-1:0]   ifm_address_write_next,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  start_to_next,
    output logic                  ifm_sel_next
);

    state_t                state;
    logic [15:0]           ch, orow, ocol, kr, kc, nch, norow, nocol;
    logic [ADDR_OUT-1:0]   wr_idx;
    logic [1:0]            free, nfree;
    logic                  avg_mode, rd_d, first_d, older;
    logic                  kend, last_k, last_col, last_row, last_win;
    logic [DATA_WIDTH-1:0] result, wdata;

    function automatic logic [ADDR_IN-1:0] win_addr(input logic [15:0] c, input logic [15:0] r, input logic [15:0] q);
        return ADDR_IN'(32'(c) * IFM_SIZE * IFM_SIZE + 32'(r) * STRIDE * IFM_SIZE + 32'(q) * STRIDE);
    endfunction

    pool_reduce #(.DATA_WIDTH(DATA_WIDTH), .KERNEL_SIZE(KERNEL_SIZE)) u_reduce (
        .clk    (clk),
        .reset  (reset),
        .first  (first_d),
        .valid  (rd_d),
        .mode   (avg_mode),
        .data   (data_in),
        .result (result)
    );

    // loop-end detection, next window position, bank free flags and write-stage value
    always_comb begin
        kend     = kc == 16'(KERNEL_SIZE - 1);
        last_k   = kend && (kr == 16'(KERNEL_SIZE - 1));
        last_col = ocol == 16'(OFM_SIZE - 1);
        last_row = orow == 16'(OFM_SIZE - 1);
        last_win = last_col && last_row && (ch == 16'(IFM_DEPTH - 1));
        nocol    = last_col ? 16'd0 : ocol + 16'd1;
        norow    = !last_col ? orow : last_row ? 16'd0 : orow + 16'd1;
        nch      = (last_col && last_row) ? ch + 16'd1 : ch;
        older    = (free == 2'b00) ? ifm_sel_next : free[0];
        nfree    = free | ((end_from_next && free != 2'b11) ? 2'b01 << older : 2'b00);
        nfree    = (state == DONE) ? nfree & ~(2'b01 << ifm_sel_next) : nfree;
`ifdef POOL_RELU_EN
        wdata    = result[DATA_WIDTH-1] ? '0 : result;
`else
        wdata    = result;
`endif
    end

    // job sequencer: window walk, read/write strobes, handshakes and bank selection
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            {ch, orow, ocol, kr, kc} <= '0;
            wr_idx                 <= '0;
            free                   <= 2'b11;
            {avg_mode, rd_d, first_d} <= '0;
            ifm_enable_read        <= 1'b0;
            ifm_address_read       <= '0;
            ifm_enable_write_next  <= 1'b0;
            ifm_address_write_next <= '0;
            data_out               <= '0;
            end_to_previous        <= 1'b0;
            start_to_next          <= 1'b0;
            ifm_sel_next           <= 1'b0;
        end else begin
            free    <= nfree;
            rd_d    <= ifm_enable_read;
            first_d <= ifm_enable_read && kr == 16'd0 && kc == 16'd0;
            case (state)
                IDLE: if (start_from_previous) begin
                    avg_mode         <= mode_avg;
                    {ch, orow, ocol, kr, kc} <= '0;
                    wr_idx           <= '0;
                    ifm_address_read <= '0;
                    ifm_enable_read  <= free[ifm_sel_next];
                    state            <= free[ifm_sel_next] ? FETCH : WAIT_BUF;
                end
                WAIT_BUF: if (free[ifm_sel_next]) begin
                    ifm_enable_read <= 1'b1;
                    state           <= FETCH;
                end
                FETCH: begin
                    kc               <= kend ? 16'd0 : kc + 16'd1;
                    kr               <= last_k ? 16'd0 : kend ? kr + 16'd1 : kr;
                    ifm_address_read <= ifm_address_read + (kend ? ADDR_IN'(IFM_SIZE - KERNEL_SIZE + 1) : ADDR_IN'(1));
                    if (last_k) begin
                        ifm_enable_read <= 1'b0;
                        state           <= DRAIN;
                    end
                end
                DRAIN: begin
                    ifm_enable_write_next  <= 1'b1;
                    ifm_address_write_next <= wr_idx;
                    data_out               <= wdata;
                    wr_idx                 <= wr_idx + 1'b1;
                    state                  <= WRITE;
                end
                WRITE: begin
                    ifm_enable_write_next <= 1'b0;
                    if (last_win) begin
                        end_to_previous <= 1'b1;
                        start_to_next   <= 1'b1;
                        state           <= DONE;
                    end else begin
                        ch               <= nch;
                        orow             <= norow;
                        ocol             <= nocol;
                        ifm_address_read <= win_addr(nch, norow, nocol);
                        ifm_enable_read  <= 1'b1;
                        state            <= FETCH;
                    end
                end
                DONE: begin
                    end_to_previous <= 1'b0;
                    start_to_next   <= 1'b0;
                    ifm_sel_next    <= ~ifm_sel_next;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
